// File: rtl/front_pipe_regs_pkg.sv
// -----------------------------------------------------------------------------
// front_pipe_regs_pkg
// Shared constants for the front half (PC, IF/ID, ID/EX) of the 5-stage MIPS
// pipeline: control-bundle layout, nop encoding, reset PC and instruction
// field helpers.
// -----------------------------------------------------------------------------
package front_pipe_regs_pkg;

    // Control bundle layout, MSB first:
    // RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, ALUOp[2:0]
    localparam int CTRL_BUNDLE_W = 10;
    localparam int REGWRITE_IDX  = 9;
    localparam int MEMTOREG_IDX  = 8;
    localparam int BRANCH_IDX    = 7;
    localparam int MEMREAD_IDX   = 6;
    localparam int MEMWRITE_IDX  = 5;
    localparam int REGDST_IDX    = 4;
    localparam int ALUSRC_IDX    = 3;
    localparam int ALUOP_MSB     = 2;
    localparam int ALUOP_LSB     = 0;

    // sll $0,$0,0 encodes as all zeros, so a cleared register is a nop.
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    // Register-number fields of an R/I-type instruction.
    function automatic logic [4:0] instr_rs(input logic [31:0] instr);
        return instr[25:21];
    endfunction

    function automatic logic [4:0] instr_rt(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[15:11];
    endfunction

endpackage

// File: rtl/front_pipe_regs_pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
// Generic W-bit pipeline register.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, loads RST_VAL
//   en_i   : load enable
//   clr_i  : synchronous clear to zero, takes priority over en_i
//   d_i    : next data
//   q_o    : registered data
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/front_pipe_regs.sv
// -----------------------------------------------------------------------------
// front_pipe_regs
// Sequential state of the front half of the 5-stage MIPS pipeline: PC register,
// IF/ID register and ID/EX register, driven by the hazard unit's PCWrite,
// IF/ID write, IF/ID flush and ID/EX flush controls. Also counts load-use stall
// cycles and IF/ID flush events (both saturating).
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   pc_next_i                 next PC (PC+4 or branch target)
//   instr_i                   instruction memory output for pc_o
//   pc_write_i                PC load enable
//   write_ifid_i              IF/ID load enable
//   flush_ifid_i              IF/ID flush (wins over write_ifid_i)
//   flush_idex_i              ID/EX bubble insert
//   ctrl_id_i, rs_data_id_i,
//   rt_data_id_i, imm_id_i    ID-stage control bundle and operands
//   pc_o                      current PC
//   pc4_ifid_o, instr_ifid_o,
//   valid_ifid_o              IF/ID contents
//   ctrl_idex_o, memread_idex_o, pc4_idex_o, rs_data_idex_o, rt_data_idex_o,
//   imm_idex_o, rs_idex_o, rt_idex_o, rd_idex_o, valid_idex_o
//                             ID/EX contents
//   stall_cnt_o, flush_cnt_o  performance counters
// -----------------------------------------------------------------------------
module front_pipe_regs
    import front_pipe_regs_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int          CTRL_W      = CTRL_BUNDLE_W,
    parameter int          MEMREAD_BIT = MEMREAD_IDX,
    parameter int          CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       pc_next_i,
    input  logic [31:0]       instr_i,
    input  logic              pc_write_i,
    input  logic              write_ifid_i,
    input  logic              flush_ifid_i,
    input  logic              flush_idex_i,
    input  logic [CTRL_W-1:0] ctrl_id_i,
    input  logic [31:0]       rs_data_id_i,
    input  logic [31:0]       rt_data_id_i,
    input  logic [31:0]       imm_id_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc4_ifid_o,
    output logic [31:0]       instr_ifid_o,
    output logic              valid_ifid_o,
    output logic [CTRL_W-1:0] ctrl_idex_o,
    output logic              memread_idex_o,
    output logic [31:0]       pc4_idex_o,
    output logic [31:0]       rs_data_idex_o,
    output logic [31:0]       rt_data_idex_o,
    output logic [31:0]       imm_idex_o,
    output logic [4:0]        rs_idex_o,
    output logic [4:0]        rt_idex_o,
    output logic [4:0]        rd_idex_o,
    output logic              valid_idex_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int IFID_W = 1 + 32 + 32;
    localparam int IDEX_W = CTRL_W + 1 + 4 * 32 + 3 * 5;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // ---------------- PC stage ----------------
    pipe_reg #(
        .W       (32),
        .RST_VAL (RESET_PC)
    ) u_pc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (pc_write_i),
        .clr_i (1'b0),
        .d_i   (pc_next_i),
        .q_o   (pc_o)
    );

    // ---------------- IF/ID stage ----------------
    // Clearing the whole group on flush yields instr = NOP_INSTR, pc4 = 0,
    // valid = 0. The PC+4 adder wraps naturally modulo 2^32.
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_q;
    logic [31:0]       pc4_if;

    assign pc4_if = pc_o + PC_STEP;
    assign ifid_d = {1'b1, pc4_if, instr_i};

    pipe_reg #(
        .W       (IFID_W),
        .RST_VAL ({1'b0, 32'h0, NOP_INSTR})
    ) u_ifid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (write_ifid_i),
        .clr_i (flush_ifid_i),
        .d_i   (ifid_d),
        .q_o   (ifid_q)
    );

    assign valid_ifid_o = ifid_q[64];
    assign pc4_ifid_o   = ifid_q[63:32];
    assign instr_ifid_o = ifid_q[31:0];

    // ---------------- ID/EX stage ----------------
    // Loads every cycle; a flush inserts an all-zero bubble, so every control
    // bit (notably RegWrite/MemWrite/MemRead) is deasserted.
    logic [IDEX_W-1:0] idex_d;
    logic [IDEX_W-1:0] idex_q;

    assign idex_d = {ctrl_id_i,
                     valid_ifid_o,
                     pc4_ifid_o,
                     rs_data_id_i,
                     rt_data_id_i,
                     imm_id_i,
                     instr_rs(instr_ifid_o),
                     instr_rt(instr_ifid_o),
                     instr_rd(instr_ifid_o)};

    pipe_reg #(
        .W       (IDEX_W),
        .RST_VAL ('0)
    ) u_idex (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (1'b1),
        .clr_i (flush_idex_i),
        .d_i   (idex_d),
        .q_o   (idex_q)
    );

    assign {ctrl_idex_o,
            valid_idex_o,
            pc4_idex_o,
            rs_data_idex_o,
            rt_data_idex_o,
            imm_idex_o,
            rs_idex_o,
            rt_idex_o,
            rd_idex_o} = idex_q;

    assign memread_idex_o = ctrl_idex_o[MEMREAD_BIT];

    // ---------------- Performance counters ----------------
    // A load-use stall is PC and IF/ID both frozen with no IF/ID flush.
    logic             stall_evt;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    assign stall_evt = ~pc_write_i & ~write_ifid_i & ~flush_ifid_i;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (flush_ifid_i) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: doc/front_pipe_regs.md
Name: front_pipe_regs

Overview:
- Holds the sequential state of the front half of the 5-stage MIPS pipeline: the PC register, the IF/ID register and the ID/EX register.
- Sits directly downstream of the hazard detection unit and consumes its PCWrite, IF/ID write, IF/ID flush and ID/EX flush controls.
- Feeds the hazard unit's inputs back to it: the ID/EX MemRead bit and the ID/EX rt field.
- Also counts load-use stall cycles and branch-flush events for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 10, width of the ID-stage control bundle: RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc, ALUOp[2:0], with MSB = RegWrite.
- MEMREAD_BIT, 6, bit index of MemRead within the control bundle.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  pipeline clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- pc_next_i  in  32  next PC chosen upstream (PC+4 or branch target)
- instr_i  in  32  instruction memory output for pc_o
- pc_write_i  in  1  PC load enable (hazard PCWrite)
- write_ifid_i  in  1  IF/ID load enable
- flush_ifid_i  in  1  IF/ID flush
- flush_idex_i  in  1  ID/EX bubble insert
- ctrl_id_i  in  CTRL_W  decoder control bundle for the instruction in ID
- rs_data_id_i  in  32  register file read data 1
- rt_data_id_i  in  32  register file read data 2
- imm_id_i  in  32  sign-extended immediate
- pc_o  out  32  current PC
- pc4_ifid_o  out  32  IF/ID PC+4
- instr_ifid_o  out  32  IF/ID instruction
- valid_ifid_o  out  1  IF/ID holds a real instruction
- ctrl_idex_o  out  CTRL_W  ID/EX control bundle
- memread_idex_o  out  1  ctrl_idex_o[MEMREAD_BIT], to the hazard unit
- pc4_idex_o, rs_data_idex_o, rt_data_idex_o, imm_idex_o  out  32 each  ID/EX datapath fields
- rs_idex_o, rt_idex_o, rd_idex_o  out  5 each  instr[25:21], [20:16], [15:11] captured from IF/ID
- valid_idex_o  out  1  ID/EX holds a real instruction
- stall_cnt_o  out  CNT_W  load-use stall cycles
- flush_cnt_o  out  CNT_W  IF/ID flush events

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - pc_o = RESET_PC.
  - All IF/ID and ID/EX fields = 0, both valid bits = 0.
  - Both counters = 0.
  - All outputs are registers, so every output is 0 during reset except pc_o.
- PC register:
  - pc_write_i = 1: pc_o <= pc_next_i.
  - pc_write_i = 0: pc_o holds.
- IF/ID register, priority order:
  1. flush_ifid_i = 1: clear instr and pc4 to 0 (0 is the sll $0 nop) and set valid = 0. This wins even when write_ifid_i = 1, so the branch code 11111 flushes.
  2. write_ifid_i = 0: hold all fields.
  3. Otherwise: instr <= instr_i, pc4 <= pc_o + 32'd4 (modulo 2^32, wraps at 32'hFFFF_FFFC), valid <= 1.
- ID/EX register:
  - flush_idex_i = 1: every field = 0 and valid = 0, so the bubble has all control deasserted.
  - Otherwise it loads every cycle (no hold): the ID inputs, pc4/valid from IF/ID, and register fields sliced from instr_ifid_o.
- Latency: one cycle per register stage. The IF/ID and ID/EX contents have no combinational path from inputs to outputs.
- Stall counter: +1 on each edge where pc_write_i = 0 and write_ifid_i = 0 and flush_ifid_i = 0 (load-use code 00010). Saturates at all-ones, no wrap.
- Flush counter: +1 on each edge where flush_ifid_i = 1. Saturates at all-ones.
- Simultaneous events:
  - pc_write_i = 0 with write_ifid_i = 1 is legal: IF/ID reloads the same instruction.
  - A flush arriving during a stall: flush priority applies per register independently.

Decomposition:
- Shared package: CTRL_W, the bit index constants for each control field, NOP_INSTR = 32'h0, RESET_PC default.
- One natural sub-module: pipe_reg, a generic W-bit register with async active-high reset, enable and synchronous clear (clear over enable). Instantiate it for each stage field group.
- Counters stay inline.

Test Plan:
- Reset then release, pc_write=1, write_ifid=1, pc_next = pc+4 → pc_o 0, 4, 8. instr_ifid_o follows instr_i one cycle late. valid_ifid_o goes to 1 after the first edge.
- Load-use code 00010 for one cycle with ctrl_id_i = 10'h3FF → pc_o and IF/ID unchanged. Next cycle ctrl_idex_o = 0, valid_idex_o = 0, stall_cnt_o = 1.
- Branch code 11111 with pc_next_i = 32'h40 → pc_o = 32'h40, instr_ifid_o = 0, valid_ifid_o = 0, ID/EX zeroed, flush_cnt_o = 1.
- ID/EX capture: instr_ifid_o = 32'h8C22_0004 (lw $2,4($1)) with ctrl MemRead set → rs_idex_o = 1, rt_idex_o = 2, memread_idex_o = 1 one edge later.
- PC = 32'hFFFF_FFFC with normal flow → pc4_ifid_o = 0 (wrap).
- Assert rst_i mid-stream between clock edges → all outputs clear immediately (pc_o = RESET_PC) without a clock edge. Pre-load counters to all-ones and hold stall code → stall_cnt_o stays at all-ones.
